// File: rtl/fft_dec.sv
// Dominant-frequency detector: L1 magnitude per bin, peak search over bins 1..FFT_SIZE/2-1,
// peak index scaled to Hz. Define FFTDEC_THRESH_EN to report 0 Hz for peaks below MAG_THRESH.
module fft_dec #(
    parameter int BIT_WIDTH  = 16,
    parameter int N          = 9,
    parameter int FFT_SIZE   = 512,
    parameter int FS         = 48000,
    parameter int MAG_THRESH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fft_done,
    input  logic [2*BIT_WIDTH-1:0] fft_result,
    output logic [BIT_WIDTH:0]     frequency,
    output logic                   note_dec
);

    localparam int MW     = BIT_WIDTH + 1;
    localparam int PW_MIN = N + $clog2(FS + 1);
    // Product is kept at least one bit wider than the output so saturation is detectable.
    localparam int PW     = (PW_MIN > MW) ? PW_MIN : MW + 1;

    localparam logic [N-1:0]  LAST_IDX = N'(FFT_SIZE - 1);
    localparam logic [N-1:0]  HALF_IDX = N'(FFT_SIZE / 2);
    localparam logic [PW-1:0] FS_W     = PW'(FS);
    localparam logic [PW-1:0] FREQ_MAX = (PW'(1) << MW) - PW'(1);

    if (FFT_SIZE != (1 << N) || MAG_THRESH < 0) begin : g_bad_cfg
        $error("fft_dec: FFT_SIZE must equal 2**N and MAG_THRESH must be non-negative");
    end

    // Input tagging and magnitude approximation
    logic [N-1:0]  bin_cnt_reg;
    logic [MW-1:0] comp_abs [2];
    logic [MW-1:0] mag_next;

    for (genvar gi = 0; gi < 2; gi++) begin : g_abs
        logic [MW-1:0] comp_ext;
        assign comp_ext     = {fft_result[gi*BIT_WIDTH + BIT_WIDTH - 1],
                               fft_result[gi*BIT_WIDTH +: BIT_WIDTH]};
        assign comp_abs[gi] = comp_ext[MW-1] ? (~comp_ext + MW'(1)) : comp_ext;
    end

    // Each |component| is at most 2^(BIT_WIDTH-1), so the sum fits in MW bits.
    assign mag_next = comp_abs[0] + comp_abs[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_cnt_reg <= '0;
        end else if (fft_done) begin
            bin_cnt_reg <= (bin_cnt_reg == LAST_IDX) ? '0 : bin_cnt_reg + N'(1);
        end
    end

    // Stage 1: magnitude with its bin index
    logic          s1_valid_reg;
    logic [N-1:0]  s1_idx_reg;
    logic [MW-1:0] s1_mag_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_idx_reg   <= '0;
            s1_mag_reg   <= '0;
        end else begin
            s1_valid_reg <= fft_done;
            if (fft_done) begin
                s1_idx_reg <= bin_cnt_reg;
                s1_mag_reg <= mag_next;
            end
        end
    end

    // Stage 2: running peak over the positive half; index 0 restarts the search
    logic [MW-1:0] peak_mag_reg;
    logic [N-1:0]  peak_idx_reg;
    logic          s2_last_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_mag_reg <= '0;
            peak_idx_reg <= '0;
            s2_last_reg  <= 1'b0;
        end else begin
            s2_last_reg <= s1_valid_reg && (s1_idx_reg == LAST_IDX);
            if (s1_valid_reg) begin
                if (s1_idx_reg == '0) begin
                    peak_mag_reg <= '0;
                    peak_idx_reg <= '0;
                end else if (s1_idx_reg < HALF_IDX && s1_mag_reg > peak_mag_reg) begin
                    peak_mag_reg <= s1_mag_reg;
                    peak_idx_reg <= s1_idx_reg;
                end
            end
        end
    end

    // Stage 3a: scale the winning index; captured before the next frame's index 0 clears the peak
    logic          s3_valid_reg;
    logic [PW-1:0] s3_prod_reg;
`ifdef FFTDEC_THRESH_EN
    logic [MW-1:0] s3_mag_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_valid_reg <= 1'b0;
            s3_prod_reg  <= '0;
`ifdef FFTDEC_THRESH_EN
            s3_mag_reg   <= '0;
`endif
        end else begin
            s3_valid_reg <= s2_last_reg;
            if (s2_last_reg) begin
                s3_prod_reg <= PW'(peak_idx_reg) * FS_W;
`ifdef FFTDEC_THRESH_EN
                s3_mag_reg  <= peak_mag_reg;
`endif
            end
        end
    end

    // Stage 3b: truncate, saturate and publish
    logic [PW-1:0] quot;
    logic [MW-1:0] freq_next;
    logic [MW-1:0] freq_reg;
    logic          note_reg;

    assign quot = s3_prod_reg >> N;

    always_comb begin
        freq_next = (quot > FREQ_MAX) ? {MW{1'b1}} : quot[MW-1:0];
`ifdef FFTDEC_THRESH_EN
        if (s3_mag_reg < MW'(MAG_THRESH)) begin
            freq_next = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freq_reg <= '0;
            note_reg <= 1'b0;
        end else begin
            note_reg <= s3_valid_reg;
            if (s3_valid_reg) begin
                freq_reg <= freq_next;
            end
        end
    end

    assign frequency = freq_reg;
    assign note_dec  = note_reg;

endmodule

// File: tb/tb_fft_dec.sv
// Scoreboard bench for fft_dec: frames push expected Hz and pulse cycle, a monitor checks each note_dec.
module tb_fft_dec;

    localparam int BW = 16;
    localparam int FSZ = 512;

    logic            clk = 1'b0;
    logic            reset;
    logic            fft_done;
    logic [2*BW-1:0] fft_result;
    logic [BW:0]     frequency;
    logic            note_dec;

    fft_dec #(.BIT_WIDTH(BW), .N(9), .FFT_SIZE(FSZ), .FS(48000), .MAG_THRESH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .fft_done   (fft_done),
        .fft_result (fft_result),
        .frequency  (frequency),
        .note_dec   (note_dec)
    );

    always #5 clk = ~clk;

    typedef struct {
        int freq;
        int due;
        string name;
    } exp_t;

    exp_t        sb_q[$];
    int          edge_no = 0;
    int          total = 0;
    int          bad = 0;
    int          last_e = 0;
    int          last_exp = 0;
    int          prev_freq = 0;
    logic [31:0] frame [FSZ];

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Monitor: every pulse must match the oldest expectation, and frequency must hold otherwise
    always @(negedge clk) begin
        if (!reset) begin
            if (note_dec) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_pulse: got note_dec=1 freq=%0d, expected no pulse", frequency);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check({e.name, "_freq"}, int'(frequency), e.freq);
                    check({e.name, "_cycle"}, edge_no, e.due);
                    $display("pulse %s: freq=%0d at edge %0d", e.name, frequency, edge_no);
                end
            end else if (int'(frequency) != prev_freq) begin
                bad++;
                $display("FAIL freq_hold: got %0d, expected %0d (no pulse)", frequency, prev_freq);
            end
        end
        prev_freq = int'(frequency);
    end

    task automatic clear_frame();
        for (int i = 0; i < FSZ; i++) frame[i] = 32'h0;
    endtask

    task automatic send_frame(input string name, input int exp_freq, input int n_bins,
                              input int stall_every);
        for (int i = 0; i < n_bins; i++) begin
            fft_done   = 1'b1;
            fft_result = frame[i];
            @(posedge clk);
            #1;
            last_e = edge_no;
            if (stall_every > 0 && (i + 1) % stall_every == 0 && i != n_bins - 1) begin
                fft_done   = 1'b0;
                fft_result = 32'h7FFF_7FFF;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        if (n_bins == FSZ) begin
            sb_q.push_back('{freq: exp_freq, due: last_e + 3, name: name});
            last_exp = exp_freq;
            $display("frame %s sent: expect freq=%0d at edge %0d", name, exp_freq, last_e + 3);
        end
    endtask

    initial begin
        int thresh_exp;
        reset      = 1'b1;
        fft_done   = 1'b0;
        fft_result = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_freq", int'(frequency), 0);
        check("reset_note", int'(note_dec), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        clear_frame(); frame[10] = 32'h1000_0000;
        send_frame("tone10", 937, FSZ, 0);

        clear_frame(); frame[5] = 32'h0000_E000; frame[40] = 32'h0100_0000;
        send_frame("neg_imag", 468, FSZ, 0);

        clear_frame(); frame[0] = 32'h7FFF_7FFF; frame[3] = 32'h0010_0000;
        send_frame("dc_excl", 281, FSZ, 0);

        clear_frame(); frame[20] = 32'h0800_0000; frame[30] = 32'h0800_0000;
        frame[300] = 32'h7FFF_0000;
        send_frame("tie_mirror", 1875, FSZ, 0);

        clear_frame(); frame[7] = 32'h8000_0000; frame[8] = 32'h7FFF_0000;
        send_frame("min_neg", 656, FSZ, 0);

        clear_frame(); frame[255] = 32'h0001_0000; frame[256] = 32'h7FFF_7FFF;
        send_frame("top_bin", 23906, FSZ, 0);

        clear_frame(); frame[10] = 32'h1000_0000;
        send_frame("stalls", 937, FSZ, 50);

        clear_frame();
        send_frame("all_zero", 0, FSZ, 0);

`ifdef FFTDEC_THRESH_EN
        thresh_exp = 0;
`else
        thresh_exp = 937;
`endif
        clear_frame(); frame[10] = 32'h0020_0000;
        send_frame("low_mag", thresh_exp, FSZ, 0);

        // Partial frame, then asynchronous reset mid-frame
        clear_frame(); frame[100] = 32'h4000_0000;
        send_frame("partial", 0, 200, 0);
        fft_done = 1'b0;
        @(negedge clk);
        check("pre_reset_freq", int'(frequency), thresh_exp);
        #2 reset = 1'b1;
        #1;
        check("async_reset_freq", int'(frequency), 0);
        check("async_reset_note", int'(note_dec), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        clear_frame(); frame[64] = 32'h2000_0000;
        send_frame("bin64", 6000, FSZ, 0);
        clear_frame(); frame[128] = 32'h2000_0000;
        send_frame("bin128", 12000, FSZ, 0);
        fft_done = 1'b0;

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        repeat (5) @(negedge clk);
        check("final_hold", int'(frequency), last_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_dec.md
Name: fft_dec

Overview:
- Dominant-frequency detector placed after the FFT core.
- Accepts one complex FFT bin per clock while fft_done is high and approximates each bin's magnitude.
- Finds the peak bin in the positive-frequency half, excluding DC, and converts its index to Hz.
- Publishes the frequency with a one-cycle note_dec strobe for the note-classification logic.

Parameters:
- BIT_WIDTH, 16: width of each signed real/imag component.
- N, 9: log2(FFT_SIZE).
- FFT_SIZE, 512: bins per frame; must equal 2^N.
- FS, 48000: sample rate in Hz.
- MAG_THRESH, 64: minimum peak magnitude; used only with FFTDEC_THRESH_EN.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- fft_done  input  1  bin-valid; high = fft_result carries the next bin, consumed this edge.
- fft_result  input  2*BIT_WIDTH  [2*BIT_WIDTH-1:BIT_WIDTH] = signed real, [BIT_WIDTH-1:0] = signed imag.
- frequency  output  BIT_WIDTH+1  peak frequency in Hz, unsigned, held between frames.
- note_dec  output  1  one-cycle pulse: new frequency valid.

Behaviour:
- Reset (async, active-high):
  - frequency=0, note_dec=0, bin counter=0.
  - Pipeline valids cleared; peak magnitude and peak index cleared.
- Input acceptance:
  - Each rising edge with fft_done=1 accepts one bin.
  - A bin counter (N bits) tags the bin with its index 0..FFT_SIZE-1, then increments.
  - The counter wraps from FFT_SIZE-1 to 0, so the next accepted bin starts a new frame.
  - fft_done=0 stalls: counter holds and nothing is accepted. Gaps of any length are legal mid-frame.
- Stage 1, registered:
  - mag = |re| + |im| (L1 approximation), BIT_WIDTH+1 bits unsigned.
  - |-2^(BIT_WIDTH-1)| = 2^(BIT_WIDTH-1); no overflow.
  - Index and valid travel with mag.
- Stage 2, registered:
  - When the stage-1 index is 0: peak_mag=0 and peak_idx=0 (frame start; DC bin never wins).
  - For index 1..FFT_SIZE/2-1: if mag > peak_mag (strict), load peak_mag=mag and peak_idx=index. Ties keep the lower index.
  - Indices FFT_SIZE/2..FFT_SIZE-1 (mirror half) are ignored.
- Stage 3, triggered when stage 2 has processed index FFT_SIZE-1:
  - frequency = (peak_idx * FS) >> N, truncated.
  - Use a product width of at least N+ceil(log2 FS) bits; saturate to all ones if the result exceeds BIT_WIDTH+1 bits.
  - note_dec=1 for exactly one cycle.
- Latency:
  - Last bin accepted on edge E; frequency updated and note_dec high after edge E+3; note_dec low after E+4.
  - Back-to-back frames: one result per FFT_SIZE accepted bins. Frame k+1 bins may enter while frame k drains; the per-bin index tagging keeps frames separate.
- All-zero frame or no bin above 0: peak_idx=0, so frequency=0 and note_dec still pulses.
- Reset mid-frame: partial frame discarded, no note_dec; the next accepted bin is index 0.
- frequency changes only on the note_dec cycle.

Optional Feature:
- FFTDEC_THRESH_EN defined:
  - In stage 3, if peak_mag < MAG_THRESH, frequency is loaded with 0 (no note).
  - note_dec still pulses.
- Undefined: no threshold check; MAG_THRESH unused.

Test Plan:
- Single tone: bin 10 real=0x1000, all other bins 0, fft_done held high 512 cycles -> note_dec pulses 3 cycles after the last bin; frequency=937.
- Negative/imag components: bin 5 imag=0xE000 (-8192), bin 40 real=0x0100 -> frequency=468. DC bin 0 = 0x7FFF7FFF with bin 3 = 0x00100000 -> frequency=281.
- Tie and mirror: bins 20 and 30 both real=0x0800; bin 300 real=0x7FFF -> frequency=1875 (lower index wins, mirror ignored).
- Stalls: same frame as the single-tone case with fft_done dropped for 3 cycles every 50 bins -> frequency=937; single note_dec pulse 3 cycles after the final accepted bin.
- Reset/back-to-back:
  - Assert reset after 200 bins, then send a full frame with peak bin 64 -> no pulse before the reset; frequency=6000.
  - Immediately follow with a frame peaking at bin 128 -> second pulse, frequency=12000.
- All-zero frame -> frequency=0, note_dec pulses. With FFTDEC_THRESH_EN and a bin 10 magnitude of 32 -> frequency=0.
